inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the RV32C core: owns the fetch PC and fetches 32-bit words from instruction memory over a req/ack handshake. It splits each word into 16-bit parcels, buffers them in a 4-parcel queue, and presents one parcel per cycle with its PC to the decoder over a valid/ready handshake. Branch and jump redirects from the execute stage flush the queue and restart fetch at the new target.

## Interface
- RESET_PC, default 32'h0000_0000: fetch address after reset; bit 0 ignored.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  read request to instruction memory
- mem_addr  output  32  word address; bits [1:0] always 0
- mem_ack  input  1  one-cycle pulse; mem_rdata valid in this cycle
- mem_rdata  input  32  fetched word; low parcel = bits [15:0]
- redirect  input  1  one-cycle pulse; restart fetch at redirect_pc
- redirect_pc  input  32  new fetch target; bit 0 ignored
- inst_valid  output  1  inst / inst_pc hold a valid parcel
- inst  output  16  parcel at head of queue
- inst_pc  output  32  byte address of inst
- inst_ready  input  1  consumer accepts head parcel this cycle
- inst_illegal  output  1  head parcel has inst[1:0]==2'b11 (see Configuration)

## Operation
- Registered state:
  - fetch_pc: word address of the next request.
  - head_pc: PC of the queue head.
  - Queue: 4 × 16-bit parcels, with read pointer and count 0..4.
  - FSM: IDLE, WAIT, DISCARD.
  - drop_low: 1 bit.
- IDLE:
  - If count ≤ 2 and no redirect, assert mem_req with mem_addr = fetch_pc and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - mem_req stays high and mem_addr stays stable until mem_ack.
  - On mem_ack, push both parcels (low first) and advance fetch_pc by 4, then go to IDLE.
  - If drop_low is set, push only the high parcel and clear drop_low.
- DISCARD:
  - Entered when a redirect arrives in WAIT without mem_ack.
  - mem_req stays high with the old address until mem_ack. The returned data is dropped, then go to IDLE.
  - Only one request is outstanding at any time.
- Pop: when inst_valid && inst_ready, advance the read pointer, decrement count, and add 2 to head_pc.
- inst_valid = (count != 0).
- Redirect, which has priority over everything else:
  - Clears the queue (count = 0). Any pop in the same cycle is cancelled.
  - fetch_pc = {redirect_pc[31:2], 2'b00}, head_pc = {redirect_pc[31:1], 1'b0}, drop_low = redirect_pc[1].
  - From IDLE: go to IDLE; the new request issues next cycle.
  - From WAIT with mem_ack in the same cycle: the ack data is dropped and the FSM goes to IDLE.
  - From WAIT without mem_ack: go to DISCARD.
  - From DISCARD: stay in DISCARD and update the target fields.
- Room guarantee: a request issues only when count ≤ 2, and count cannot grow while a request is outstanding. An ack therefore always fits.
- Push and pop in the same cycle: count = count + pushed − 1.
- Arithmetic:
  - fetch_pc and head_pc are 32-bit and wrap modulo 2^32.
  - Queue pointers wrap modulo 4.

## Timing
- Reset values:
  - mem_req = 0, mem_addr = {RESET_PC[31:2], 2'b00}.
  - inst_valid = 0, inst = 0, inst_pc = {RESET_PC[31:1], 1'b0}, inst_illegal = 0.
  - FSM = IDLE, count = 0, drop_low = RESET_PC[1].
- First mem_req is asserted in the first cycle after reset deasserts.
- Latency: mem_ack in cycle N gives inst_valid = 1 in cycle N+1.
- Redirect in cycle N:
  - inst_valid = 0 from cycle N+1.
  - Earliest new mem_req is in cycle N+1, or the cycle after the pending ack if the FSM is in DISCARD.
- Throughput: with zero-wait memory (ack the cycle after req), the unit sustains one parcel per cycle.
- inst, inst_pc and inst_illegal are driven from registers and the queue head only; there is no combinational path from mem_rdata.
- Reset asserted mid-request: all state returns to reset values immediately. An ack arriving while reset is asserted is ignored.

## Configuration
- IFETCH_ILLEGAL_CHECK_EN:
  - Defined: inst_illegal = inst_valid && inst[1:0]==2'b11. This flags 32-bit encodings, which the RV32C-only core cannot execute.
  - Undefined: inst_illegal is tied to 0 and no check logic is built.

## Test plan
- Reset with RESET_PC=0 and memory acking one cycle after req, word0 = 32'h4505_4581 → mem_addr=0. Then inst=16'h4581 with inst_pc=0, followed by inst=16'h4505 with inst_pc=2, on consecutive cycles with inst_ready=1.
- inst_ready held 0 → at most two requests issue and count saturates at 4. mem_req stays 0 until a pop brings count to ≤ 2.
- Redirect to 32'h0000_0102 while in IDLE → next mem_addr=32'h100, and only the high parcel is queued with inst_pc=32'h102.
- Redirect while in WAIT, with ack 3 cycles later → mem_addr held stable until the ack, that data is dropped, and the next request uses the redirect address.
- Redirect and mem_ack in the same cycle → ack data is not queued, and inst_valid = 0 in the next cycle.
- With IFETCH_ILLEGAL_CHECK_EN defined, memory word 32'h0000_0013 → the first parcel 16'h0013 shows inst_illegal=1. With the macro undefined, inst_illegal stays 0.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32C instruction fetch: word fetch, 4-parcel queue, redirect flush
//
// Parameters:
//   RESET_PC      fetch address after reset (bit 0 ignored)
// Optional build macro:
//   IFETCH_ILLEGAL_CHECK_EN  when defined, inst_illegal flags a valid head parcel
//                            with inst[1:0]==2'b11; otherwise inst_illegal is 0
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   mem_req       read request to instruction memory (held until mem_ack)
//   mem_addr      word address of the request, bits [1:0] always 0
//   mem_ack       one-cycle pulse, mem_rdata valid in this cycle
//   mem_rdata     fetched word, low parcel in bits [15:0]
//   redirect      one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc   new fetch target (bit 0 ignored)
//   inst_valid    inst / inst_pc hold a valid parcel
//   inst          parcel at the queue head
//   inst_pc       byte address of inst
//   inst_ready    consumer accepts the head parcel this cycle
//   inst_illegal  head parcel is a 32-bit encoding (see macro above)
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        inst_illegal
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    localparam logic [31:0] RESET_WORD = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_HALF = RESET_PC & 32'hFFFF_FFFE;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] head_pc;
    logic        drop_low;
    logic [15:0] queue [4];
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  count_nxt;

    logic        issue;
    logic        ack_take;
    logic        push_lo;
    logic        push_hi;
    logic        pop;
    logic [2:0]  n_push;
    logic [1:0]  wr_ptr;
    logic [1:0]  wr_ptr_p1;
    logic [31:0] redir_word;
    logic [31:0] redir_half;

    assign redir_word = redirect_pc & 32'hFFFF_FFFC;
    assign redir_half = redirect_pc & 32'hFFFF_FFFE;

    // A new request needs room for two parcels. Gating with the reset input
    // keeps mem_req low while reset is held even though IDLE/count 0 would
    // otherwise request.
    assign issue = reset && (state == S_IDLE) && (count <= 3'd2) && !redirect;

    assign mem_req  = issue || (state == S_WAIT) || (state == S_DISCARD);
    // While a request is outstanding the address comes from req_pc, because
    // a redirect in WAIT rewrites fetch_pc before the old ack returns.
    assign mem_addr = (state == S_IDLE) ? fetch_pc : req_pc;

    // Ack data is only queued in WAIT; a same-cycle redirect drops it.
    assign ack_take = (state == S_WAIT) && mem_ack && !redirect;
    assign push_hi  = ack_take;
    assign push_lo  = ack_take && !drop_low;
    assign n_push   = push_lo ? 3'd2 : (push_hi ? 3'd1 : 3'd0);

    assign inst_valid = (count != 3'd0);
    assign pop        = inst_valid && inst_ready && !redirect;

    // Pushes only happen with count <= 2, so count[1:0] is the true fill level.
    assign wr_ptr    = rd_ptr + count[1:0];
    assign wr_ptr_p1 = wr_ptr + 2'd1;

    always_comb begin
        count_nxt = count;
        if (redirect) begin
            count_nxt = 3'd0;
        end else begin
            count_nxt = count + n_push - (pop ? 3'd1 : 3'd0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_nxt = S_IDLE;
                end else if (redirect) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The ack closes the stale request even if another redirect
                // arrives alongside it; the new target is already captured.
                if (mem_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_WORD;
            req_pc   <= RESET_WORD;
            head_pc  <= RESET_HALF;
            drop_low <= RESET_PC[1];
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                queue[i] <= 16'h0000;
            end
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redir_word;
                head_pc  <= redir_half;
                drop_low <= redir_half[1];
            end else begin
                if (ack_take) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    drop_low <= 1'b0;
                end
                if (pop) begin
                    head_pc <= head_pc + 32'd2;
                    rd_ptr  <= rd_ptr + 2'd1;
                end
            end
            if (push_lo) begin
                queue[wr_ptr]    <= mem_rdata[15:0];
                queue[wr_ptr_p1] <= mem_rdata[31:16];
            end else if (push_hi) begin
                queue[wr_ptr] <= mem_rdata[31:16];
            end
        end
    end

    assign inst    = inst_valid ? queue[rd_ptr] : 16'h0000;
    assign inst_pc = head_pc;

`ifdef IFETCH_ILLEGAL_CHECK_EN
    assign inst_illegal = inst_valid && (inst[1:0] == 2'b11);
`else
    assign inst_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        inst_illegal;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .inst_illegal (inst_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int pops    = 0;
    int mem_lat = 1;
    logic [31:0] exp_next = 32'h0;
    logic [48:0] sb [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ill(input logic [15:0] p);
`ifdef IFETCH_ILLEGAL_CHECK_EN
        return p[1:0] == 2'b11;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h000: return 32'h4505_4581;
            32'h004: return 32'h8082_0001;
            32'h008: return 32'h0000_0013;
            32'h00C: return 32'h1111_2222;
            32'h100: return 32'hAAAA_5555;
            32'h104: return 32'h0000_0000;
            32'h200: return 32'hCCCC_3333;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_p(input logic [31:0] pc, input logic [15:0] p);
        sb.push_back({ill(p), pc, p});
    endtask

    // Parcel monitor: every accepted parcel is compared with the scoreboard.
    always @(negedge clock) begin
        logic [48:0] e;
        if (reset && inst_valid && inst_ready && !redirect) begin
            pops++;
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_pop: got inst %h pc %h expected none", inst, inst_pc);
            end else begin
                e = sb.pop_front();
                check("inst", {16'h0, inst}, {16'h0, e[15:0]});
                check("inst_pc", inst_pc, e[47:16]);
                check("inst_illegal", {31'h0, inst_illegal}, {31'h0, e[48]});
            end
        end
    end

    // Memory model: acks mem_lat cycles after the request is seen, checks
    // request addresses against exp_next and that requests hold steady.
    logic        busy = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] paddr = 32'h0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            if (reset && !mem_ack) begin
                if (busy) begin
                    check("req_hold", {31'h0, mem_req}, 32'h1);
                    check("addr_hold", mem_addr, paddr);
                end else if (mem_req) begin
                    check("req_addr", mem_addr, exp_next);
                    paddr    = mem_addr;
                    busy     = 1'b1;
                    wait_cnt = mem_lat;
                    exp_next = exp_next + 32'd4;
                end
            end
            @(posedge clock);
            #1;
            mem_ack = 1'b0;
            if (busy) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    busy      = 1'b0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(paddr);
                end
            end
        end
    end

    task automatic consume(input int n, output int first_cyc, output int span);
        int start;
        int t;
        first_cyc = -1;
        span = -1;
        @(posedge clock);
        #1;
        start = pops;
        t = 0;
        inst_ready = 1'b1;
        while ((pops - start) < n && t < 60) begin
            @(negedge clock);
            #1;
            t++;
            if (first_cyc < 0 && pops > start) first_cyc = cyc;
        end
        if ((pops - start) < n) begin
            vectors++;
            errors++;
            $display("FAIL consume_timeout: got %0d pops expected %0d", pops - start, n);
        end else begin
            span = cyc - first_cyc;
        end
        @(posedge clock);
        #1;
        inst_ready = 1'b0;
    endtask

    task automatic settle();
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while ((mem_req || mem_ack) && t < 40);
        if (mem_req || mem_ack) begin
            vectors++;
            errors++;
            $display("FAIL settle_timeout: got mem_req %b expected 0", mem_req);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        check({tag, "_inst"}, {16'h0, inst}, 32'h0);
        check({tag, "_inst_pc"}, inst_pc, 32'h0);
        check({tag, "_inst_illegal"}, {31'h0, inst_illegal}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int fc;
        int sp;
        reset       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values, then first fetch and two-parcel stream.
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check_reset_state("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        c0 = cyc;
        @(negedge clock);
        check("first_req", {31'h0, mem_req}, 32'h1);
        check("first_addr", mem_addr, 32'h0);
        expect_p(32'h0, 16'h4581);
        expect_p(32'h2, 16'h4505);
        consume(2, fc, sp);
        check("first_pop_latency", fc, c0 + 2);
        check("stream_span2", sp, 1);

        // Saturation: queue fills to 4 and requests stop until count <= 2.
        settle();
        repeat (3) begin
            @(negedge clock);
            check("sat_no_req", {31'h0, mem_req}, 32'h0);
        end
        check("sat_head", {16'h0, inst}, 32'h0000_0001);
        check("sat_head_pc", inst_pc, 32'h4);
        expect_p(32'h4, 16'h0001);
        consume(1, fc, sp);
        @(negedge clock);
        check("cnt3_no_req", {31'h0, mem_req}, 32'h0);
        expect_p(32'h6, 16'h8082);
        consume(1, fc, sp);
        @(negedge clock);
        check("cnt2_req", {31'h0, mem_req}, 32'h1);
        check("cnt2_addr", mem_addr, 32'hC);

        // Zero-wait throughput and illegal flag on 16'h0013.
        expect_p(32'h8, 16'h0013);
        expect_p(32'hA, 16'h0000);
        expect_p(32'hC, 16'h2222);
        expect_p(32'hE, 16'h1111);
        consume(4, fc, sp);
        check("stream_span4", sp, 3);

        // Redirect in IDLE to an odd-parcel target.
        settle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        exp_next    = 32'h100;
        @(negedge clock);
        check("redir_idle_no_req", {31'h0, mem_req}, 32'h0);
        @(posedge clock);
        #1;
        redirect = 1'b0;
        @(negedge clock);
        check("redir_idle_flush", {31'h0, inst_valid}, 32'h0);
        check("redir_idle_req", {31'h0, mem_req}, 32'h1);
        check("redir_idle_addr", mem_addr, 32'h100);
        repeat (2) @(negedge clock);
        check("drop_low_head", {16'h0, inst}, 32'h0000_AAAA);
        check("drop_low_pc", inst_pc, 32'h102);
        expect_p(32'h102, 16'hAAAA);
        consume(1, fc, sp);

        // Redirect in WAIT with a slow ack: stale data is dropped.
        settle();
        mem_lat = 3;
        expect_p(32'h104, 16'h0000);
        expect_p(32'h106, 16'h0000);
        consume(2, fc, sp);
        @(negedge clock);
        check("wait_req_addr", mem_addr, 32'h10C);
        @(posedge clock);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_next    = 32'h200;
        @(posedge clock);
        #1;
        redirect = 1'b0;
        @(negedge clock);
        check("discard_flush", {31'h0, inst_valid}, 32'h0);
        check("discard_addr", mem_addr, 32'h10C);
        repeat (2) begin
            @(posedge clock);
            #1;
            @(negedge clock);
        end
        check("post_discard_req", {31'h0, mem_req}, 32'h1);
        check("post_discard_addr", mem_addr, 32'h200);
        expect_p(32'h200, 16'h3333);
        expect_p(32'h202, 16'hCCCC);
        consume(2, fc, sp);

        // Redirect in the same cycle as mem_ack.
        settle();
        mem_lat     = 1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0010;
        exp_next    = 32'h10;
        @(posedge clock);
        #1;
        redirect = 1'b0;
        @(negedge clock);
        check("ack_redir_req", mem_addr, 32'h10);
        @(posedge clock);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0008;
        exp_next    = 32'h8;
        @(posedge clock);
        #1;
        redirect = 1'b0;
        @(negedge clock);
        check("ack_redir_flush", {31'h0, inst_valid}, 32'h0);
        check("ack_redir_addr", mem_addr, 32'h8);
        expect_p(32'h8, 16'h0013);
        expect_p(32'hA, 16'h0000);
        consume(2, fc, sp);

        // Reset asserted mid-request; the ack during reset is ignored.
        settle();
        mem_lat     = 2;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0000;
        exp_next    = 32'h0;
        @(posedge clock);
        #1;
        redirect = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        exp_next = 32'h0;
        @(negedge clock);
        check_reset_state("midrst");
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        mem_lat = 1;
        reset   = 1'b1;
        expect_p(32'h0, 16'h4581);
        expect_p(32'h2, 16'h4505);
        consume(2, fc, sp);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
